// File: rtl/button_conditioner.sv
// button_conditioner: two independent push-button channels, each with a
// 2-flop synchronizer, a RELEASED/HELD debounce FSM and one-cycle press and
// release strobes. The debounced level is asserted while the FSM is in HELD.
// Optional auto-repeat of press_pulse is compiled in when the macro
// BUTTON_AUTOREPEAT_EN is defined; without it, HOLD_CYCLES and REPEAT_CYCLES
// only affect the counter width.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn_n,
    output logic [1:0] pressed,
    output logic [1:0] press_pulse,
    output logic [1:0] release_pulse
);

    localparam int MAX_DH     = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYCLES = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic {
        RELEASED = 1'b0,
        HELD     = 1'b1
    } state_t;

    logic [1:0] sync_meta;
    logic [1:0] sync_q;

    // Two-flop synchronizer; resets to the released (high) level so that reset
    // itself never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= 2'b11;
            sync_q    <= 2'b11;
        end else begin
            sync_meta <= btn_n;
            sync_q    <= sync_meta;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
        logic          press_q, press_d;
        logic          release_q, release_d;
`ifdef BUTTON_AUTOREPEAT_EN
        logic [CW-1:0] rpt_q, rpt_d, rpt_inc;
        logic          rpt_phase_q, rpt_phase_d;  // 0: waiting HOLD, 1: repeating

        assign rpt_inc = (rpt_q == CNT_MAX) ? rpt_q : rpt_q + CW'(1);
`endif

        assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

        // State, counters and registered strobes for this channel.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q     <= RELEASED;
                cnt_q       <= '0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
                rpt_q       <= '0;
                rpt_phase_q <= 1'b0;
`endif
            end else begin
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                press_q     <= press_d;
                release_q   <= release_d;
`ifdef BUTTON_AUTOREPEAT_EN
                rpt_q       <= rpt_d;
                rpt_phase_q <= rpt_phase_d;
`endif
            end
        end

        // Next state: count consecutive samples that disagree with the current
        // debounced level; the DEBOUNCE_CYCLES-th one flips the level.
        always_comb begin
            state_d     = state_q;
            cnt_d       = '0;
            press_d     = 1'b0;
            release_d   = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            rpt_d       = '0;
            rpt_phase_d = 1'b0;
`endif
            case (state_q)
                RELEASED: begin
                    if (!sync_q[ch]) begin
                        if (cnt_q == DEB_LAST) begin
                            state_d = HELD;
                            press_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                HELD: begin
                    if (sync_q[ch]) begin
                        if (cnt_q == DEB_LAST) begin
                            state_d   = RELEASED;
                            release_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
`ifdef BUTTON_AUTOREPEAT_EN
                        // Repeat timer runs only while the button stays down.
                        if (rpt_q == (rpt_phase_q ? REP_LAST : HOLD_LAST)) begin
                            press_d     = 1'b1;
                            rpt_phase_d = 1'b1;
                        end else begin
                            rpt_d       = rpt_inc;
                            rpt_phase_d = rpt_phase_q;
                        end
`endif
                    end
                end
                default: state_d = RELEASED;
            endcase
        end

        assign pressed[ch]       = (state_q == HELD);
        assign press_pulse[ch]   = press_q;
        assign release_pulse[ch] = release_q;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DEBOUNCE_CYCLES, 500000, stable-sample count required to accept a change; legal minimum 2.
- HOLD_CYCLES, 25000000, held time before the first auto-repeat pulse.
- REPEAT_CYCLES, 5000000, interval between auto-repeat pulses.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn_n  input  2  raw push-buttons, active-low (1 = released); feeds CPU_datapath button1/button2.
- pressed  output  2  debounced level, active-high.
- press_pulse  output  2  one-cycle strobe on accepted press (and on repeats).
- release_pulse  output  2  one-cycle strobe on accepted release.

Function
REQ-003 Each channel SHALL be fully independent; simultaneous activity on both channels SHALL produce the same per-channel timing as activity on one channel alone.
REQ-004 Each btn_n bit SHALL pass through a 2-flop synchronizer; all later logic SHALL use only the synchronized value (sync).
REQ-005 Each channel SHALL run a two-state FSM, RELEASED and HELD, with a saturating counter whose width is ceil(log2(max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)+1)).
REQ-006 In RELEASED, the counter SHALL increment on every cycle that sync = 0, and SHALL clear on any cycle that sync = 1.
REQ-007 When sync = 0 and the counter = DEBOUNCE_CYCLES-1, the next edge SHALL enter HELD, set pressed = 1, pulse press_pulse for exactly one cycle, and clear the counter.
REQ-008 Press latency: for btn_n held low from edge 0, press_pulse SHALL be high during the cycle following edge DEBOUNCE_CYCLES+2.
REQ-009 In HELD, the counter SHALL count cycles with sync = 1 and clear on sync = 0; on reaching DEBOUNCE_CYCLES-1, the next edge SHALL enter RELEASED, clear pressed, and pulse release_pulse for one cycle.
REQ-010 Release latency SHALL be symmetric with REQ-008.
REQ-011 Any bounce shorter than DEBOUNCE_CYCLES samples SHALL produce no change on any output.
REQ-012 press_pulse and release_pulse SHALL never be high together on the same channel; each pulse SHALL be exactly one cycle wide.

Reset
REQ-013 Asserting rst = 0 SHALL immediately, without waiting for a clock edge, force:
- synchronizer flops to 1;
- state to RELEASED;
- counters to 0;
- pressed, press_pulse and release_pulse to 0.
REQ-014 A reset applied mid-debounce or mid-hold SHALL discard all progress. After rst releases with the button still held, a full DEBOUNCE_CYCLES+2 qualification SHALL be required before press_pulse.
REQ-015 No output SHALL pulse as a result of reset assertion or deassertion alone.

Configuration
REQ-016 The macro BUTTON_AUTOREPEAT_EN SHALL control auto-repeat.
- Defined: while in HELD with sync = 0 continuously, a separate repeat counter SHALL issue:
  - an additional one-cycle press_pulse HOLD_CYCLES cycles after the initial press pulse;
  - further pulses every REPEAT_CYCLES cycles after that;
  - the repeat counter SHALL clear on leaving HELD.
- Undefined: exactly one press_pulse per accepted press. The repeat logic SHALL be absent, and HOLD_CYCLES and REPEAT_CYCLES SHALL have no effect.

Verification
REQ-017 Benches SHALL use DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 20, REPEAT_CYCLES = 8, and SHALL cover these scenarios:
- Clean press: btn_n[0] = 0 from edge 0 -> press_pulse[0] high for one cycle after edge 6; pressed[0] = 1 thereafter; channel 1 outputs stay 0.
- Bounce reject: btn_n[1] toggles 0/1 every 2 cycles for 20 cycles, then returns to 1 -> all channel 1 outputs stay 0.
- Release: after an accepted press, btn_n[0] = 1 for 6 cycles -> release_pulse[0] one cycle after the 6th edge; pressed[0] = 0.
- Reset mid-debounce: btn_n[0] = 0, rst = 0 at cycle 3 for 2 cycles, button still held -> no pulse until 6 edges after rst returns high.
- Auto-repeat (macro defined): btn_n[0] held 60 cycles -> press_pulses at cycles 6, 26, 34, 42, 50, 58. Macro undefined -> single pulse at cycle 6.
- Simultaneous: both buttons pressed at edge 0 -> both press_pulse bits high in the same cycle.
